// File: rtl/adder_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter_pkg
// Shared definitions for the arbitrated adder and its result buffer.
//
// Contents:
//   calc_id_w()     - width of a requester index: max(1, clog2(n)).
//   occ_state_t     - occupancy states of the 2-entry result buffer.
//   result_entry_t  - result entry {id, sum} at the default sizing
//                     (width = 8, n_req = 4). The top builds the same
//                     {id, sum} layout at its own parameter sizes.
//
// Configuration macro: ADDER_ARB_ROUND_ROBIN_EN (used by adder_rr_arbiter).
// -----------------------------------------------------------------------------
package adder_rr_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_REQ = 4;
    localparam int MAX_N_REQ     = 16;

    // Index width for n requesters; a single requester still gets one bit
    // so sum_id never collapses to zero width.
    function automatic int calc_id_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy of the 2-deep result buffer. Hierarchical checkers can
    // bind to the buffer's "state" register, which uses this type.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [calc_id_w(DEFAULT_N_REQ)-1:0] id;
        logic [DEFAULT_WIDTH:0]              sum;
    } result_entry_t;

endpackage

// File: rtl/adder_arb_result_fifo.sv
// -----------------------------------------------------------------------------
// adder_arb_result_fifo
// Two-entry in-order result buffer between the arbiter and the sum port.
//
// Handshake (both sides): a beat moves only in a cycle where vld and rdy
// are both 1 at the rising clock edge. The producer holds its data stable
// while vld=1 and rdy=0; dn_data is stable while dn_vld=1 and dn_rdy=0.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   up_vld / up_rdy   - write side; up_rdy is a register (1 = not full)
//   up_data           - entry written on a write beat
//   dn_vld / dn_rdy   - read side; dn_vld is a register (1 = not empty)
//   dn_data           - oldest entry, driven straight from the head register
//
// The occupancy FSM (state) keeps the head entry in "head" and the second
// entry in "tail"; a read while full moves tail into head.
// -----------------------------------------------------------------------------
module adder_arb_result_fifo
    import adder_rr_arbiter_pkg::*;
#(
    parameter type entry_t = result_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   up_vld,
    output logic   up_rdy,
    input  entry_t up_data,
    output logic   dn_vld,
    input  logic   dn_rdy,
    output entry_t dn_data
);

    occ_state_t state;
    entry_t     head;
    entry_t     tail;
    logic       push;
    logic       pop;

    assign push    = up_vld & up_rdy;
    assign pop     = dn_vld & dn_rdy;
    assign dn_data = head;

    // up_rdy and dn_vld are registered outputs of the occupancy FSM, so the
    // write side never sees a combinational path from dn_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OCC_EMPTY;
            head   <= '0;
            tail   <= '0;
            dn_vld <= 1'b0;
            up_rdy <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head   <= up_data;
                        dn_vld <= 1'b1;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        // Occupancy stays at one; the new entry replaces
                        // the one being read.
                        head <= up_data;
                    end else if (push) begin
                        tail   <= up_data;
                        up_rdy <= 1'b0;
                        state  <= OCC_FULL;
                    end else if (pop) begin
                        dn_vld <= 1'b0;
                        state  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // up_rdy is 0 here, so only a read can happen.
                    if (pop) begin
                        head   <= tail;
                        up_rdy <= 1'b1;
                        state  <= OCC_ONE;
                    end
                end
                default: begin
                    state  <= OCC_EMPTY;
                    dn_vld <= 1'b0;
                    up_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
// n_req requesters each offer an operand pair (A, B). One winner per cycle
// is chosen, A + B (carry kept) is computed and pushed, tagged with the
// winner's index, into a 2-entry in-order result buffer that drives the
// sum port.
//
// Handshake (all channels): a transfer happens only in a cycle where vld
// and rdy are both 1 at the rising clock edge. At most one req_rdy bit is
// 1 per cycle, and req_rdy never depends on sum_rdy or on operand data.
//
// Parameters:
//   width  - operand width in bits (sum is width+1 bits)
//   n_req  - number of requesters, 2..16
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_vld      - per-requester operand-pair valid
//   req_rdy      - per-requester ready (one-hot or zero)
//   req_a_data   - packed operand A, requester i in [i*width +: width]
//   req_b_data   - packed operand B, same packing
//   sum_vld      - result valid
//   sum_rdy      - result ready
//   sum_data     - zero-extended A + zero-extended B
//   sum_id       - index of the requester that produced sum_data
//
// Configuration macro ADDER_ARB_ROUND_ROBIN_EN:
//   defined   - round-robin: search starts at ptr and wraps; after each
//               request transfer ptr becomes (winner + 1) mod n_req.
//   undefined - fixed priority, lowest index wins; no ptr register.
// -----------------------------------------------------------------------------
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter int width = 8,
    parameter int n_req = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [n_req-1:0]            req_vld,
    output logic [n_req-1:0]            req_rdy,
    input  logic [n_req*width-1:0]      req_a_data,
    input  logic [n_req*width-1:0]      req_b_data,
    output logic                        sum_vld,
    input  logic                        sum_rdy,
    output logic [width:0]              sum_data,
    output logic [calc_id_w(n_req)-1:0] sum_id
);

    localparam int               ID_W     = calc_id_w(n_req);
    // One extra bit so start + offset (at most 2*n_req - 2) cannot overflow
    // before the modulo fold.
    localparam int               POS_W    = ID_W + 1;
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(n_req - 1);
    localparam logic [POS_W-1:0] N_POS    = POS_W'(n_req);
    localparam logic [n_req-1:0] ONE_HOT0 = n_req'(1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [width:0]  sum;
    } entry_t;

    // Operand views per requester.
    logic [width-1:0] a_arr [n_req];
    logic [width-1:0] b_arr [n_req];

    for (genvar gi = 0; gi < n_req; gi++) begin : g_unpack
        assign a_arr[gi] = req_a_data[gi*width +: width];
        assign b_arr[gi] = req_b_data[gi*width +: width];
    end

    logic [ID_W-1:0]  start_idx;
    logic [POS_W-1:0] arb_pos;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic [n_req-1:0] grant;
    logic             fifo_up_rdy;
    logic             xfer;
    logic [width:0]   sum_calc;
    entry_t           push_entry;
    entry_t           head_entry;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr;
    assign start_idx = ptr;
`else
    assign start_idx = '0;
`endif

    // Scan n_req positions starting at start_idx, wrapping modulo n_req;
    // the first asserted req_vld wins. Only req_vld feeds the grant, so a
    // requester may drop vld before its transfer at no cost.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_pos = '0;
        for (int k = 0; k < n_req; k++) begin
            arb_pos = {1'b0, start_idx} + POS_W'(k);
            if (arb_pos >= N_POS) begin
                arb_pos = arb_pos - N_POS;
            end
            if (!found && req_vld[arb_pos[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = arb_pos[ID_W-1:0];
            end
        end
    end

    assign grant = found ? (ONE_HOT0 << winner) : '0;

    // fifo_up_rdy is a register (buffer not full). rst_n is folded in so
    // req_rdy reads 0 immediately while reset is asserted, yet arbitration
    // is live for the first edge after release.
    assign req_rdy = grant & {n_req{fifo_up_rdy & rst_n}};
    assign xfer    = found & fifo_up_rdy & rst_n;

    assign sum_calc   = {1'b0, a_arr[winner]} + {1'b0, b_arr[winner]};
    assign push_entry = '{id: winner, sum: sum_calc};

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    // ptr moves only on a request transfer; a full buffer blocks transfers
    // and therefore holds ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
    end
`endif

    adder_arb_result_fifo #(
        .entry_t (entry_t)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_vld  (found),
        .up_rdy  (fifo_up_rdy),
        .up_data (push_entry),
        .dn_vld  (sum_vld),
        .dn_rdy  (sum_rdy),
        .dn_data (head_entry)
    );

    assign sum_data = head_entry.sum;
    assign sum_id   = head_entry.id;

endmodule
